// File: rtl/spi_draw_queue_pkg.sv
// Shared definitions for the sprite draw queue and the renderer that drains it.
package spi_draw_queue_pkg;
    localparam logic [7:0] COMMAND_DRAW_SPRITE = 8'h21;
    localparam int         SPRITE_NUM          = 64;
    localparam int         SPRITE_SIZE         = 16;
    localparam int         DRAW_PAYLOAD_LEN    = 6;
    localparam int         SPRITE_ID_W         = $clog2(SPRITE_NUM);

    typedef struct packed {
        logic [SPRITE_ID_W-1:0] sprite;
        logic [15:0]            x;
        logic [15:0]            y;
        logic [7:0]             flags;
    } draw_entry_t;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } asm_state_t;
endpackage

// File: rtl/spi_draw_queue_fifo.sv
// Synchronous FIFO of draw entries; a push into a full FIFO succeeds when a pop
// happens in the same cycle.
module draw_fifo
    import spi_draw_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  draw_entry_t                wdata,
    input  logic                       pop,
    output draw_entry_t                head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    draw_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/spi_draw_queue.sv
// Assembles 6-byte DRAW_SPRITE payloads into draw entries and queues them.
// Define DRAW_CLIP_EN to silently discard fully off-screen entries at commit.
module spi_draw_queue
    import spi_draw_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = 16,
    parameter int ID_W        = $clog2(SPRITE_NUM),
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [7:0]                    in_cmd,
    input  logic [2:0]                    in_index,
    input  logic [7:0]                    in_data,
    input  logic                          in_abort,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ID_W-1:0]               out_sprite,
    output logic [15:0]                   out_x,
    output logic [15:0]                   out_y,
    output logic [7:0]                    out_flags,
    output logic [$clog2(QUEUE_DEPTH):0]  level,
    output logic [7:0]                    drop_count
);
    localparam logic [2:0] LAST_IDX = 3'(DRAW_PAYLOAD_LEN - 1);

    asm_state_t  state, state_n;
    logic [2:0]  expect_idx;
    logic [7:0]  id_r;
    logic [15:0] x_r;
    logic [15:0] y_r;

    logic        byte_ok, in_seq, commit, seq_drop, commit_drop;
    logic        bad_id, off_screen, clip_en, clipped, push, fifo_full, fifo_empty, pop;
    draw_entry_t entry, head;

    assign byte_ok = in_valid && (in_cmd == COMMAND_DRAW_SPRITE) && !in_abort;
    assign in_seq  = (state == S_IDLE) ? (in_index == 3'd0) : (in_index == expect_idx);

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (in_abort) begin
            state_n = S_IDLE;
        end else if (byte_ok) begin
            case (state)
                S_IDLE:    if (in_seq) state_n = S_COLLECT;
                S_COLLECT: if (!in_seq || in_index == LAST_IDX) state_n = S_IDLE;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        commit   = byte_ok && state == S_COLLECT && in_seq && in_index == LAST_IDX;
        seq_drop = byte_ok && !in_seq;
    end

    // Partial-entry capture; flags arrive with the committing byte itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            expect_idx <= '0;
            id_r       <= '0;
            x_r        <= '0;
            y_r        <= '0;
        end else if (byte_ok && in_seq) begin
            expect_idx <= in_index + 1'b1;
            case (in_index)
                3'd0:    id_r      <= in_data;
                3'd1:    x_r[15:8] <= in_data;
                3'd2:    x_r[7:0]  <= in_data;
                3'd3:    y_r[15:8] <= in_data;
                3'd4:    y_r[7:0]  <= in_data;
                default: ;
            endcase
        end
    end

`ifdef DRAW_CLIP_EN
    assign clip_en = 1'b1;
`else
    assign clip_en = 1'b0;
`endif

    assign off_screen = (int'($signed(x_r)) >= SCREEN_W) || (int'($signed(y_r)) >= SCREEN_H) ||
                        (int'($signed(x_r)) <= -SPRITE_SIZE) || (int'($signed(y_r)) <= -SPRITE_SIZE);
    assign bad_id      = (int'(id_r) >= SPRITE_NUM);
    assign clipped     = clip_en && off_screen;
    assign pop         = out_valid && out_ready;
    assign push        = commit && !bad_id && !clipped;
    assign commit_drop = commit && (bad_id || (!clipped && fifo_full && !pop));
    assign entry       = '{sprite: id_r[SPRITE_ID_W-1:0], x: x_r, y: y_r, flags: in_data};

    always_ff @(posedge clock) begin
        if (reset)                                           drop_count <= '0;
        else if ((seq_drop || commit_drop) && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end

    draw_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (entry),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign out_valid  = !fifo_empty;
    assign out_sprite = ID_W'(head.sprite);
    assign out_x      = head.x;
    assign out_y      = head.y;
    assign out_flags  = head.flags;
endmodule
